control_sequencer: RTL and testbench
====================================

# control_sequencer

Parametrised multi-cycle instruction sequencer; successor to the fixed 16-bit control unit. Fetches one instruction per cycle from the instruction bus, decodes the full 3/2/1/0-operand instruction set, and drives register file, logic unit, comparator, program counter and data-memory strobes. Adds a memory-ready handshake, a run/halt mechanism, illegal-instruction capture and a retired-instruction counter. Sits between the instruction memory and the datapath.

## Interface

Parameters:
- FIELD_W, 4: width of one instruction field and of each register address; instruction word INSTR_W = 4*FIELD_W.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  sampled in IDLE and HALT; 1 starts or continues execution.
- i_bus  in  INSTR_W  instruction or literal word at the current PC.
- flags  in  INSTR_W  comparator flag word.
- mem_ready  in  1  data memory accepts or completes the current access.
- d_bus  out  INSTR_W  tri-state; i_bus in LIT, flags in GTF writeback, otherwise high-Z.
- mem_read, mem_write  out  1  data-memory strobes.
- pc_increment, pc_load  out  1  PC controls.
- cmp_load, cmp_compare  out  1  comparator controls.
- alu_op  out  4  logic-unit operation code; ALU_NONE when idle.
- reg1_read, reg2_read, reg3_write  out  1  register-file strobes.
- reg1_addr, reg2_addr, reg3_addr  out  FIELD_W  register addresses.
- halted  out  1  high in HALT.
- illegal  out  1  high in HALT if entry was caused by an undefined opcode.
- bad_instr  out  INSTR_W  undefined instruction that caused the halt.
- retired  out  CNT_W  count of completed instructions.

## Operation

- Fields: F3 = top field, F2, F1, F0 = bottom field. ALL1 = all-ones field.
- F3 != ALL1: three-operand ADD 1, SUB 2, AND 3, OR 4, XOR 5, SHR 6, SHL 7; reg1=F2, reg2=F1, reg3=F0. Other F3 values are illegal.
- F3 = ALL1, F2 selects a two-operand instruction:
  - CMP 1: reg1=F1, reg2=F0, pulse cmp_compare.
  - JMP 2: reg1=F1 holds the target; F0 = ALL1 means unconditional, else pc_load only if flags[F0] = 1.
  - NEG 3 / MOV 4: reg1=F1, reg3=F0, alu_op NEG / PASS.
  - LDM 6: address in reg1=F1, destination reg3=F0.
  - STM 7: address in reg1=F1, data in reg2=F0.
- F3 = F2 = ALL1, F1 selects a one-operand instruction:
  - LDL 1: next word into reg3=F0, which skips it.
  - GTF 2: flags into reg3=F0.
  - STF 3: reg1=F0 into the comparator via cmp_load.
- FFFF is NOP. Every other encoding is illegal: go to HALT, set illegal, latch bad_instr.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, LIT, HALT.
  - IDLE to FETCH when run=1.
  - FETCH latches i_bus, pulses pc_increment, then DECODE.
  - DECODE: ALU, NEG, MOV, CMP, JMP and STF go to EXEC. LDM and STM go to MEM. LDL goes to LIT. GTF goes to WB. NOP goes to FETCH. Illegal goes to HALT.
  - EXEC: assert reg reads and alu_op or compare/load/jump. Go to WB for register results, else FETCH.
  - MEM: hold mem_read or mem_write and the reg reads until mem_ready. Then WB for LDM, FETCH for STM.
  - WB: reg3_write, then FETCH.
  - LIT: d_bus=i_bus, reg3_write, pc_increment, then FETCH.
  - HALT: leave only when run falls and rises again, which clears illegal and goes to FETCH.
- run=0 sampled at entry to FETCH goes to HALT with illegal=0.
- retired increments by 1 at the last cycle of each legal instruction, NOP included, and wraps modulo 2^CNT_W.

## Timing

- On reset, every strobe is 0, alu_op=ALU_NONE, all addresses 0, d_bus high-Z, halted=0, illegal=0, bad_instr=0, retired=0, state IDLE.
- All outputs are registered; strobes are high only in the state named and low in every other state.
- Cycles per instruction, with zero memory wait:
  - NOP 2.
  - CMP, JMP, STF, GTF, LDL 3.
  - ALU, NEG, MOV 4.
  - STM 3 and LDM 4, each +1 per cycle mem_ready is low.
- mem_ready high in the first MEM cycle completes the access in that cycle.
- Reset asserted mid-access drops mem_read and mem_write immediately; no writeback follows.
- A JMP whose condition is false asserts no pc_load and still retires.

## Structure

- Package control_pkg holds the state enum, the ALU_* codes (NONE 0, PASS 1, ADD 2, SUB 3, AND 4, OR 5, XOR 6, SHR 7, SHL 8, NEG 9) and the opcode constants.
- One sub-module, instr_decoder: combinational. Takes the instruction word and produces the instruction class, addresses, alu_op and the illegal flag.

## Test plan

- Reset mid-LDM with mem_ready=0: all outputs return to reset values within the same cycle. IDLE follows, and run=1 restarts at FETCH.
- ADD encoded 0x1234: reg1_addr=2, reg2_addr=3 and alu_op=ADD in EXEC; reg3_write with reg3_addr=4 in WB; retired=1 after 4 cycles.
- LDL 0xFF15 then literal 0xBEEF: d_bus=0xBEEF with reg3_addr=5; pc_increment pulses twice; next fetch is the following word.
- STM 0xF712 with mem_ready held low 3 cycles: mem_write high for 4 cycles, reg1_addr=1, reg2_addr=2; retired increments once.
- JMP 0xF230 with flags=0x0000 gives no pc_load. With flags=0x0001, pc_load is asserted in EXEC.
- Instruction 0x8000: HALT, illegal=1, bad_instr=0x8000, retired unchanged. Toggling run resumes at FETCH with illegal=0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and constants for the control sequencer: FSM states, instruction
// classes, logic-unit operation codes and opcode field values.
package control_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [ALU_W-1:0] ALU_NONE = 4'd0;
    localparam logic [ALU_W-1:0] ALU_PASS = 4'd1;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd4;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd5;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SHR  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SHL  = 4'd8;
    localparam logic [ALU_W-1:0] ALU_NEG  = 4'd9;

    // three-operand opcodes (top field)
    localparam int unsigned OP_ADD = 1;
    localparam int unsigned OP_SUB = 2;
    localparam int unsigned OP_AND = 3;
    localparam int unsigned OP_OR  = 4;
    localparam int unsigned OP_XOR = 5;
    localparam int unsigned OP_SHR = 6;
    localparam int unsigned OP_SHL = 7;
    // two-operand opcodes (second field)
    localparam int unsigned OP_CMP = 1;
    localparam int unsigned OP_JMP = 2;
    localparam int unsigned OP_NEG = 3;
    localparam int unsigned OP_MOV = 4;
    localparam int unsigned OP_LDM = 6;
    localparam int unsigned OP_STM = 7;
    // one-operand opcodes (third field)
    localparam int unsigned OP_LDL = 1;
    localparam int unsigned OP_GTF = 2;
    localparam int unsigned OP_STF = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_LIT, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_ALU, CLS_CMP, CLS_JMP, CLS_STF,
        CLS_LDM, CLS_STM, CLS_LDL, CLS_GTF, CLS_ILL
    } instr_cls_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic pc_increment;
        logic pc_load;
        logic cmp_load;
        logic cmp_compare;
        logic reg1_read;
        logic reg2_read;
        logic reg3_write;
    } strobes_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction-bus and datapath-control bundle between the sequencer (master)
// and the instruction memory / datapath (slave).
interface control_sequencer_if #(parameter int unsigned FIELD_W = 4);
    localparam int unsigned INSTR_W = 4 * FIELD_W;

    logic [INSTR_W-1:0]           i_bus;
    logic [INSTR_W-1:0]           flags;
    logic                         mem_ready;
    logic                         mem_read;
    logic                         mem_write;
    logic                         pc_increment;
    logic                         pc_load;
    logic                         cmp_load;
    logic                         cmp_compare;
    logic [control_pkg::ALU_W-1:0] alu_op;
    logic                         reg1_read;
    logic                         reg2_read;
    logic                         reg3_write;
    logic [FIELD_W-1:0]           reg1_addr;
    logic [FIELD_W-1:0]           reg2_addr;
    logic [FIELD_W-1:0]           reg3_addr;

    modport master (
        input  i_bus, flags, mem_ready,
        output mem_read, mem_write, pc_increment, pc_load, cmp_load, cmp_compare,
               alu_op, reg1_read, reg2_read, reg3_write, reg1_addr, reg2_addr, reg3_addr
    );

    modport slave (
        output i_bus, flags, mem_ready,
        input  mem_read, mem_write, pc_increment, pc_load, cmp_load, cmp_compare,
               alu_op, reg1_read, reg2_read, reg3_write, reg1_addr, reg2_addr, reg3_addr
    );
endinterface

// File: rtl/control_sequencer_instr_decoder.sv
// Combinational instruction decoder: class, register addresses, logic-unit
// operation and illegal flag. Unused address fields decode to zero.
module instr_decoder
    import control_pkg::*;
#(
    parameter int unsigned FIELD_W = 4
) (
    input  logic [4*FIELD_W-1:0] instr,
    output instr_cls_t           cls,
    output logic [ALU_W-1:0]     alu_op,
    output logic [FIELD_W-1:0]   reg1_addr,
    output logic [FIELD_W-1:0]   reg2_addr,
    output logic [FIELD_W-1:0]   reg3_addr,
    output logic [FIELD_W-1:0]   cond_field,
    output logic                 uses_reg1,
    output logic                 uses_reg2,
    output logic                 jmp_always,
    output logic                 illegal
);
    localparam logic [FIELD_W-1:0] ALL1 = '1;

    logic [FIELD_W-1:0] f3, f2, f1, f0;

    assign f3 = instr[4*FIELD_W-1 -: FIELD_W];
    assign f2 = instr[3*FIELD_W-1 -: FIELD_W];
    assign f1 = instr[2*FIELD_W-1 -: FIELD_W];
    assign f0 = instr[FIELD_W-1:0];
    assign cond_field = f0;
    assign illegal    = (cls == CLS_ILL);

    always_comb begin
        cls        = CLS_ILL;
        alu_op     = ALU_NONE;
        reg1_addr  = '0;
        reg2_addr  = '0;
        reg3_addr  = '0;
        uses_reg1  = 1'b0;
        uses_reg2  = 1'b0;
        jmp_always = 1'b0;
        if (f3 != ALL1) begin
            cls       = CLS_ALU;
            reg1_addr = f2;
            reg2_addr = f1;
            reg3_addr = f0;
            uses_reg1 = 1'b1;
            uses_reg2 = 1'b1;
            case (f3)
                FIELD_W'(OP_ADD): alu_op = ALU_ADD;
                FIELD_W'(OP_SUB): alu_op = ALU_SUB;
                FIELD_W'(OP_AND): alu_op = ALU_AND;
                FIELD_W'(OP_OR):  alu_op = ALU_OR;
                FIELD_W'(OP_XOR): alu_op = ALU_XOR;
                FIELD_W'(OP_SHR): alu_op = ALU_SHR;
                FIELD_W'(OP_SHL): alu_op = ALU_SHL;
                default: begin
                    cls       = CLS_ILL;
                    reg1_addr = '0;
                    reg2_addr = '0;
                    reg3_addr = '0;
                    uses_reg1 = 1'b0;
                    uses_reg2 = 1'b0;
                end
            endcase
        end else if (f2 != ALL1) begin
            case (f2)
                FIELD_W'(OP_CMP): begin
                    cls = CLS_CMP; reg1_addr = f1; reg2_addr = f0;
                    uses_reg1 = 1'b1; uses_reg2 = 1'b1;
                end
                FIELD_W'(OP_JMP): begin
                    cls = CLS_JMP; reg1_addr = f1; uses_reg1 = 1'b1;
                    jmp_always = (f0 == ALL1);
                end
                FIELD_W'(OP_NEG): begin
                    cls = CLS_ALU; alu_op = ALU_NEG;
                    reg1_addr = f1; reg3_addr = f0; uses_reg1 = 1'b1;
                end
                FIELD_W'(OP_MOV): begin
                    cls = CLS_ALU; alu_op = ALU_PASS;
                    reg1_addr = f1; reg3_addr = f0; uses_reg1 = 1'b1;
                end
                FIELD_W'(OP_LDM): begin
                    cls = CLS_LDM; reg1_addr = f1; reg3_addr = f0; uses_reg1 = 1'b1;
                end
                FIELD_W'(OP_STM): begin
                    cls = CLS_STM; reg1_addr = f1; reg2_addr = f0;
                    uses_reg1 = 1'b1; uses_reg2 = 1'b1;
                end
                default: cls = CLS_ILL;
            endcase
        end else if (f1 != ALL1) begin
            case (f1)
                FIELD_W'(OP_LDL): begin cls = CLS_LDL; reg3_addr = f0; end
                FIELD_W'(OP_GTF): begin cls = CLS_GTF; reg3_addr = f0; end
                FIELD_W'(OP_STF): begin cls = CLS_STF; reg1_addr = f0; uses_reg1 = 1'b1; end
                default: cls = CLS_ILL;
            endcase
        end else if (f0 == ALL1) begin
            cls = CLS_NOP;
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute FSM driving the
// datapath strobes, with run/halt control, illegal capture and retire counter.
module control_sequencer
    import control_pkg::*;
#(
    parameter int unsigned FIELD_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    control_sequencer_if.master    bus,
    output wire  [4*FIELD_W-1:0]   d_bus,
    output logic                   halted,
    output logic                   illegal,
    output logic [4*FIELD_W-1:0]   bad_instr,
    output logic [CNT_W-1:0]       retired
);
    localparam int unsigned INSTR_W = 4 * FIELD_W;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 run_low_q, run_low_d;
    strobes_t             str_q, str_d;
    logic [ALU_W-1:0]     alu_op_q, alu_op_d;
    logic [FIELD_W-1:0]   reg1_addr_q, reg1_addr_d;
    logic [FIELD_W-1:0]   reg2_addr_q, reg2_addr_d;
    logic [FIELD_W-1:0]   reg3_addr_q, reg3_addr_d;
    logic [INSTR_W-1:0]   d_out_q, d_out_d;
    logic                 d_oe_q, d_oe_d;
    logic                 halted_q, halted_d;
    logic                 illegal_q, illegal_d;
    logic [INSTR_W-1:0]   bad_instr_q, bad_instr_d;
    logic [CNT_W-1:0]     retired_q, retired_d;

    instr_cls_t           cls;
    logic [ALU_W-1:0]     dec_alu_op;
    logic [FIELD_W-1:0]   dec_reg1, dec_reg2, dec_reg3, dec_cond;
    logic                 dec_uses1, dec_uses2, dec_jmp_always, dec_illegal;
    logic [INSTR_W-1:0]   flag_word;
    logic                 retire;
    logic                 goto_fetch;

    instr_decoder #(.FIELD_W(FIELD_W)) u_decoder (
        .instr      (ir_q),
        .cls        (cls),
        .alu_op     (dec_alu_op),
        .reg1_addr  (dec_reg1),
        .reg2_addr  (dec_reg2),
        .reg3_addr  (dec_reg3),
        .cond_field (dec_cond),
        .uses_reg1  (dec_uses1),
        .uses_reg2  (dec_uses2),
        .jmp_always (dec_jmp_always),
        .illegal    (dec_illegal)
    );

    // Next state, then outputs derived from the next state so each registered
    // strobe is high exactly during the state it belongs to.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        run_low_d   = run_low_q;
        illegal_d   = illegal_q;
        bad_instr_d = bad_instr_q;
        retired_d   = retired_q;
        retire      = 1'b0;
        goto_fetch  = 1'b0;
        flag_word   = bus.flags >> dec_cond;

        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = bus.i_bus;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d     = S_HALT;
                    illegal_d   = 1'b1;
                    bad_instr_d = ir_q;
                end else begin
                    case (cls)
                        CLS_NOP:          begin retire = 1'b1; goto_fetch = 1'b1; end
                        CLS_LDM, CLS_STM: state_d = S_MEM;
                        CLS_LDL:          state_d = S_LIT;
                        CLS_GTF:          state_d = S_WB;
                        default:          state_d = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                if (cls == CLS_ALU) state_d = S_WB;
                else begin retire = 1'b1; goto_fetch = 1'b1; end
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (cls == CLS_LDM) state_d = S_WB;
                    else begin retire = 1'b1; goto_fetch = 1'b1; end
                end
            end
            S_WB, S_LIT: begin
                retire     = 1'b1;
                goto_fetch = 1'b1;
            end
            S_HALT: begin
                // resume needs a fresh rising edge of run after entering HALT
                if (!run) run_low_d = 1'b1;
                else if (run_low_q) begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (goto_fetch) state_d = run ? S_FETCH : S_HALT;
        if (state_d == S_HALT && state_q != S_HALT) run_low_d = 1'b0;
        if (retire) retired_d = retired_q + CNT_W'(1);

        str_d       = '0;
        alu_op_d    = ALU_NONE;
        reg1_addr_d = '0;
        reg2_addr_d = '0;
        reg3_addr_d = '0;
        d_out_d     = '0;
        d_oe_d      = 1'b0;
        halted_d    = (state_d == S_HALT);

        case (state_d)
            S_FETCH: str_d.pc_increment = 1'b1;
            S_EXEC: begin
                str_d.reg1_read   = dec_uses1;
                str_d.reg2_read   = dec_uses2;
                reg1_addr_d       = dec_reg1;
                reg2_addr_d       = dec_reg2;
                alu_op_d          = dec_alu_op;
                str_d.cmp_compare = (cls == CLS_CMP);
                str_d.cmp_load    = (cls == CLS_STF);
                str_d.pc_load     = (cls == CLS_JMP) && (dec_jmp_always || flag_word[0]);
            end
            S_MEM: begin
                str_d.reg1_read = dec_uses1;
                str_d.reg2_read = dec_uses2;
                reg1_addr_d     = dec_reg1;
                reg2_addr_d     = dec_reg2;
                str_d.mem_read  = (cls == CLS_LDM);
                str_d.mem_write = (cls == CLS_STM);
            end
            S_WB: begin
                str_d.reg3_write = 1'b1;
                reg3_addr_d      = dec_reg3;
                if (cls == CLS_GTF) begin
                    d_oe_d  = 1'b1;
                    d_out_d = bus.flags;
                end
            end
            S_LIT: begin
                str_d.reg3_write   = 1'b1;
                str_d.pc_increment = 1'b1;
                reg3_addr_d        = dec_reg3;
                d_oe_d             = 1'b1;
                d_out_d            = bus.i_bus;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            run_low_q   <= 1'b0;
            str_q       <= '0;
            alu_op_q    <= ALU_NONE;
            reg1_addr_q <= '0;
            reg2_addr_q <= '0;
            reg3_addr_q <= '0;
            d_out_q     <= '0;
            d_oe_q      <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            bad_instr_q <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            run_low_q   <= run_low_d;
            str_q       <= str_d;
            alu_op_q    <= alu_op_d;
            reg1_addr_q <= reg1_addr_d;
            reg2_addr_q <= reg2_addr_d;
            reg3_addr_q <= reg3_addr_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            bad_instr_q <= bad_instr_d;
            retired_q   <= retired_d;
        end
    end

    assign bus.mem_read     = str_q.mem_read;
    assign bus.mem_write    = str_q.mem_write;
    assign bus.pc_increment = str_q.pc_increment;
    assign bus.pc_load      = str_q.pc_load;
    assign bus.cmp_load     = str_q.cmp_load;
    assign bus.cmp_compare  = str_q.cmp_compare;
    assign bus.reg1_read    = str_q.reg1_read;
    assign bus.reg2_read    = str_q.reg2_read;
    assign bus.reg3_write   = str_q.reg3_write;
    assign bus.alu_op       = alu_op_q;
    assign bus.reg1_addr    = reg1_addr_q;
    assign bus.reg2_addr    = reg2_addr_q;
    assign bus.reg3_addr    = reg3_addr_q;

    assign d_bus     = d_oe_q ? d_out_q : {INSTR_W{1'bz}};
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign bad_instr = bad_instr_q;
    assign retired   = retired_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction signature vectors checked via a
// scoreboard, plus reset-mid-access, halt/resume and run-drop sequences.
module tb_control_sequencer;
    import control_pkg::*;

    localparam int unsigned FIELD_W = 4;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 16;
    localparam int          TO      = 60;
    localparam int          NV      = 24;

    localparam logic [8:0] M_RD  = 9'h001, M_WR = 9'h002, M_INC = 9'h004;
    localparam logic [8:0] M_LD  = 9'h008, M_CL = 9'h010, M_CC  = 9'h020;
    localparam logic [8:0] M_R1  = 9'h040, M_R2 = 9'h080, M_R3  = 9'h100;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] lit;
        logic [15:0] flags;
        int          wait_n;
        logic        ill;
        int          cyc;
        logic [8:0]  mask;
        logic [3:0]  alu;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [3:0]  a3;
        logic [15:0] dval;
        int          pcinc;
        int          memcyc;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [8:0]  mask;
        logic [3:0]  alu;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [3:0]  a3;
        logic [15:0] dval;
        int          pcinc;
        int          memcyc;
        logic        ill;
        logic [15:0] bad;
        logic [15:0] ret;
        logic        done;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    wire  [INSTR_W-1:0] d_bus;
    logic              halted;
    logic              illegal;
    logic [INSTR_W-1:0] bad_instr;
    logic [CNT_W-1:0]  retired;

    logic [15:0] prog [8];
    logic [2:0]  pc;
    wire  [8:0]  strb;

    vec_t vecs [NV];
    vec_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    control_sequencer_if #(.FIELD_W(FIELD_W)) bus ();

    control_sequencer #(.FIELD_W(FIELD_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .bus       (bus),
        .d_bus     (d_bus),
        .halted    (halted),
        .illegal   (illegal),
        .bad_instr (bad_instr),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // program counter model driven by the DUT's PC strobes
    always @(posedge clk or posedge rst) begin
        if (rst)                  pc <= 3'd0;
        else if (bus.pc_load)     pc <= 3'd5;
        else if (bus.pc_increment) pc <= pc + 3'd1;
    end

    assign bus.i_bus = prog[pc];
    assign strb = {bus.reg3_write, bus.reg2_read, bus.reg1_read, bus.cmp_compare,
                   bus.cmp_load, bus.pc_load, bus.pc_increment, bus.mem_write, bus.mem_read};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1);
        for (int i = 0; i < 8; i++) prog[i] = 16'hFFFF;
        prog[0] = w0;
        prog[1] = w1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_one(input vec_t v, output obs_t o);
        bit started;
        int t;
        int memn;
        o = '{default: 0};
        load_prog(v.instr, v.lit);
        bus.flags = v.flags;
        do_reset();
        exp_q.push_back(v);
        run = 1'b1;
        started = 0;
        t = 0;
        memn = 0;
        for (int k = 0; k < TO && !o.done; k++) begin
            @(negedge clk);
            if (!started && bus.pc_increment) started = 1;
            if (started) begin
                if ((!v.ill && retired != '0) || (v.ill && halted)) begin
                    o.done = 1'b1;
                    o.cyc  = t;
                    o.ill  = illegal;
                    o.bad  = bad_instr;
                    o.ret  = retired;
                end else begin
                    o.mask |= strb;
                    if (bus.alu_op != ALU_NONE) o.alu = bus.alu_op;
                    if (bus.reg1_read)  o.a1 = bus.reg1_addr;
                    if (bus.reg2_read)  o.a2 = bus.reg2_addr;
                    if (bus.reg3_write) begin o.a3 = bus.reg3_addr; o.dval = d_bus; end
                    if (bus.pc_increment) o.pcinc++;
                    if (bus.mem_read || bus.mem_write) o.memcyc++;
                    t++;
                end
            end
            bus.mem_ready = (bus.mem_read || bus.mem_write) && (memn >= v.wait_n);
            if (bus.mem_read || bus.mem_write) memn++;
        end
    endtask

    task automatic compare_vec(input int i, input obs_t o);
        vec_t e;
        string p;
        e = exp_q.pop_front();
        p = $sformatf("v%0d_%04h", i, e.instr);
        check({p, ".done"}, 32'(o.done), 32'd1);
        check({p, ".cyc"},  32'(o.cyc),  32'(e.cyc));
        check({p, ".mask"}, 32'(o.mask), 32'(e.mask));
        check({p, ".ill"},  32'(o.ill),  32'(e.ill));
        if (e.ill) begin
            check({p, ".bad"}, 32'(o.bad), 32'(e.instr));
            check({p, ".ret"}, 32'(o.ret), 32'd0);
        end else begin
            check({p, ".alu"},    32'(o.alu),    32'(e.alu));
            check({p, ".a1"},     32'(o.a1),     32'(e.a1));
            check({p, ".a2"},     32'(o.a2),     32'(e.a2));
            check({p, ".a3"},     32'(o.a3),     32'(e.a3));
            check({p, ".pcinc"},  32'(o.pcinc),  32'(e.pcinc));
            check({p, ".memcyc"}, 32'(o.memcyc), 32'(e.memcyc));
            check({p, ".ret"},    32'(o.ret),    32'd1);
            if (e.dval != 16'h0) check({p, ".dbus"}, 32'(o.dval), 32'(e.dval));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        bit   ok;
        //          instr     lit       flags    wt ill  cyc mask                       alu a1 a2 a3 dval     pci mem
        vecs[0]  = '{16'h1234, 16'hFFFF, 16'h0000, 0, 1'b0, 4, M_INC|M_R1|M_R2|M_R3, 4'd2, 4'd2, 4'd3, 4'd4, 16'h0, 1, 0};
        vecs[1]  = '{16'h2567, 16'hFFFF, 16'h0000, 0, 1'b0, 4, M_INC|M_R1|M_R2|M_R3, 4'd3, 4'd5, 4'd6, 4'd7, 16'h0, 1, 0};
        vecs[2]  = '{16'h7ABC, 16'hFFFF, 16'h0000, 0, 1'b0, 4, M_INC|M_R1|M_R2|M_R3, 4'd8, 4'hA, 4'hB, 4'hC, 16'h0, 1, 0};
        vecs[3]  = '{16'h5001, 16'hFFFF, 16'h0000, 0, 1'b0, 4, M_INC|M_R1|M_R2|M_R3, 4'd6, 4'd0, 4'd0, 4'd1, 16'h0, 1, 0};
        vecs[4]  = '{16'h6E0D, 16'hFFFF, 16'h0000, 0, 1'b0, 4, M_INC|M_R1|M_R2|M_R3, 4'd7, 4'hE, 4'd0, 4'hD, 16'h0, 1, 0};
        vecs[5]  = '{16'hF389, 16'hFFFF, 16'h0000, 0, 1'b0, 4, M_INC|M_R1|M_R3,      4'd9, 4'd8, 4'd0, 4'd9, 16'h0, 1, 0};
        vecs[6]  = '{16'hF4AB, 16'hFFFF, 16'h0000, 0, 1'b0, 4, M_INC|M_R1|M_R3,      4'd1, 4'hA, 4'd0, 4'hB, 16'h0, 1, 0};
        vecs[7]  = '{16'hF1CD, 16'hFFFF, 16'h0000, 0, 1'b0, 3, M_INC|M_CC|M_R1|M_R2, 4'd0, 4'hC, 4'hD, 4'd0, 16'h0, 1, 0};
        vecs[8]  = '{16'hF23F, 16'hFFFF, 16'h0000, 0, 1'b0, 3, M_INC|M_LD|M_R1,      4'd0, 4'd3, 4'd0, 4'd0, 16'h0, 1, 0};
        vecs[9]  = '{16'hF230, 16'hFFFF, 16'h0000, 0, 1'b0, 3, M_INC|M_R1,           4'd0, 4'd3, 4'd0, 4'd0, 16'h0, 1, 0};
        vecs[10] = '{16'hF230, 16'hFFFF, 16'h0001, 0, 1'b0, 3, M_INC|M_LD|M_R1,      4'd0, 4'd3, 4'd0, 4'd0, 16'h0, 1, 0};
        vecs[11] = '{16'hF27E, 16'hFFFF, 16'h4000, 0, 1'b0, 3, M_INC|M_LD|M_R1,      4'd0, 4'd7, 4'd0, 4'd0, 16'h0, 1, 0};
        vecs[12] = '{16'hFF3E, 16'hFFFF, 16'h0000, 0, 1'b0, 3, M_INC|M_CL|M_R1,      4'd0, 4'hE, 4'd0, 4'd0, 16'h0, 1, 0};
        vecs[13] = '{16'hFF27, 16'hFFFF, 16'h5A5A, 0, 1'b0, 3, M_INC|M_R3,           4'd0, 4'd0, 4'd0, 4'd7, 16'h5A5A, 1, 0};
        vecs[14] = '{16'hFF15, 16'hBEEF, 16'h0000, 0, 1'b0, 3, M_INC|M_R3,           4'd0, 4'd0, 4'd0, 4'd5, 16'hBEEF, 2, 0};
        vecs[15] = '{16'hF6A3, 16'hFFFF, 16'h0000, 0, 1'b0, 4, M_INC|M_RD|M_R1|M_R3, 4'd0, 4'hA, 4'd0, 4'd3, 16'h0, 1, 1};
        vecs[16] = '{16'hF6A3, 16'hFFFF, 16'h0000, 2, 1'b0, 6, M_INC|M_RD|M_R1|M_R3, 4'd0, 4'hA, 4'd0, 4'd3, 16'h0, 1, 3};
        vecs[17] = '{16'hF712, 16'hFFFF, 16'h0000, 3, 1'b0, 6, M_INC|M_WR|M_R1|M_R2, 4'd0, 4'd1, 4'd2, 4'd0, 16'h0, 1, 4};
        vecs[18] = '{16'hF712, 16'hFFFF, 16'h0000, 0, 1'b0, 3, M_INC|M_WR|M_R1|M_R2, 4'd0, 4'd1, 4'd2, 4'd0, 16'h0, 1, 1};
        vecs[19] = '{16'hFFFF, 16'hFFFF, 16'h0000, 0, 1'b0, 2, M_INC,                4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1, 0};
        vecs[20] = '{16'h8000, 16'hFFFF, 16'h0000, 0, 1'b1, 2, M_INC,                4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1, 0};
        vecs[21] = '{16'hF512, 16'hFFFF, 16'h0000, 0, 1'b1, 2, M_INC,                4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1, 0};
        vecs[22] = '{16'hFF41, 16'hFFFF, 16'h0000, 0, 1'b1, 2, M_INC,                4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1, 0};
        vecs[23] = '{16'hFFF0, 16'hFFFF, 16'h0000, 0, 1'b1, 2, M_INC,                4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1, 0};

        load_prog(16'hFFFF, 16'hFFFF);
        bus.flags = 16'h0;
        bus.mem_ready = 1'b0;
        run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset.strobes", 32'(strb), 32'd0);
        check("reset.alu_op",  32'(bus.alu_op), 32'(ALU_NONE));
        check("reset.addrs",   32'({bus.reg1_addr, bus.reg2_addr, bus.reg3_addr}), 32'd0);
        check("reset.status",  32'({halted, illegal}), 32'd0);
        check("reset.bad",     32'(bad_instr), 32'd0);
        check("reset.retired", 32'(retired), 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_one(vecs[i], o);
            compare_vec(i, o);
        end

        // reset in the middle of a stalled LDM
        load_prog(16'hF6A3, 16'hFFFF);
        do_reset();
        run = 1'b1;
        ok = 0;
        for (int k = 0; k < TO && !ok; k++) begin
            @(negedge clk);
            if (bus.mem_read) ok = 1;
        end
        check("rstmid.reached_mem", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid.strobes", 32'(strb), 32'd0);
        check("rstmid.addrs",   32'({bus.reg1_addr, bus.reg2_addr, bus.reg3_addr}), 32'd0);
        check("rstmid.alu_op",  32'(bus.alu_op), 32'(ALU_NONE));
        check("rstmid.retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.refetch", 32'(bus.pc_increment), 32'd1);
        check("rstmid.no_wb",   32'(bus.reg3_write), 32'd0);

        // illegal halt, run must fall and rise before resuming
        load_prog(16'h8000, 16'hFFFF);
        do_reset();
        run = 1'b1;
        ok = 0;
        for (int k = 0; k < TO && !ok; k++) begin
            @(negedge clk);
            if (halted) ok = 1;
        end
        check("halt.entered", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check("halt.held_run_high", 32'({halted, illegal}), 32'd3);
        check("halt.bad_instr", 32'(bad_instr), 32'h8000);
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("halt.held_run_low", 32'(halted), 32'd1);
        run = 1'b1;
        @(negedge clk);
        check("halt.resume_fetch", 32'({halted, illegal, bus.pc_increment}), 32'd1);
        ok = 0;
        for (int k = 0; k < TO && !ok; k++) begin
            @(negedge clk);
            if (retired != '0) ok = 1;
        end
        check("halt.nop_retired", 32'(retired), 32'd1);

        // run dropped mid-instruction: finish, retire, then halt without illegal
        load_prog(16'h1234, 16'hFFFF);
        do_reset();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        ok = 0;
        for (int k = 0; k < TO && !ok; k++) begin
            @(negedge clk);
            if (halted) ok = 1;
        end
        check("rundrop.halted",  32'(ok), 32'd1);
        check("rundrop.illegal", 32'(illegal), 32'd0);
        check("rundrop.retired", 32'(retired), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
